// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between requester A (priority) and B (debug/loader).
// Optional statistics counters: define DMEM_ARB_STATS_EN.
module dmem_port_arbiter #(
    parameter int DBITS        = 32,
    parameter int STARVE_LIMIT = 4
`ifdef DMEM_ARB_STATS_EN
    ,
    parameter int CNT_BITS     = 16
`endif
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_a_req,
    input  logic             i_a_we,
    input  logic [DBITS-1:0] i_a_addr,
    input  logic [DBITS-1:0] i_a_wdata,
    output logic             o_a_gnt,
    output logic             o_a_rvalid,
    output logic [DBITS-1:0] o_a_rdata,
    input  logic             i_b_req,
    input  logic             i_b_we,
    input  logic [DBITS-1:0] i_b_addr,
    input  logic [DBITS-1:0] i_b_wdata,
    input  logic             i_b_lock,
    output logic             o_b_gnt,
    output logic             o_b_rvalid,
    output logic [DBITS-1:0] o_b_rdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [CNT_BITS-1:0] o_stat_a_cnt,
    output logic [CNT_BITS-1:0] o_stat_b_cnt,
    output logic [CNT_BITS-1:0] o_stat_conflict_cnt,
`endif
    output logic             o_mem_en,
    output logic             o_mem_we,
    output logic [DBITS-1:0] o_mem_addr,
    output logic [DBITS-1:0] o_mem_wdata,
    input  logic [DBITS-1:0] i_mem_rdata
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCK_B = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_A    = 2'd1;
    localparam logic [1:0] OWN_B    = 2'd2;

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

    logic [0:0]      r_state;
    logic [SC_W-1:0] r_starve_cnt;
    logic [1:0]      r_rd_owner;
    logic [DBITS-1:0] r_a_rdata;
    logic [DBITS-1:0] r_b_rdata;

    logic w_locked;
    logic w_a_gnt;
    logic w_b_gnt;
    logic w_a_rvalid;
    logic w_b_rvalid;

    // Lock only holds while b_lock stays high; the release cycle arbitrates normally.
    assign w_locked = (r_state == S_LOCK_B) && i_b_lock;

    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (!i_reset) begin
            if (w_locked) begin
                w_b_gnt = i_b_req;
            end else if (i_a_req && i_b_req) begin
                if (r_starve_cnt == SC_MAX) w_b_gnt = 1'b1;
                else                        w_a_gnt = 1'b1;
            end else begin
                w_a_gnt = i_a_req;
                w_b_gnt = i_b_req;
            end
        end
    end

    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_a_gnt) begin
            o_mem_we    = i_a_we;
            o_mem_addr  = i_a_addr;
            o_mem_wdata = i_a_wdata;
        end else if (w_b_gnt) begin
            o_mem_we    = i_b_we;
            o_mem_addr  = i_b_addr;
            o_mem_wdata = i_b_wdata;
        end
    end

    assign o_mem_en = w_a_gnt | w_b_gnt;
    assign o_a_gnt  = w_a_gnt;
    assign o_b_gnt  = w_b_gnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
        end else begin
            if (w_b_gnt && i_b_lock)
                r_state <= S_LOCK_B;
            else if (!w_locked)
                r_state <= S_IDLE;
            if (w_b_gnt || !i_b_req)
                r_starve_cnt <= '0;
            else if (r_starve_cnt != SC_MAX)
                r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_owner <= OWN_NONE;
        end else if (w_a_gnt && !i_a_we) begin
            r_rd_owner <= OWN_A;
        end else if (w_b_gnt && !i_b_we) begin
            r_rd_owner <= OWN_B;
        end else begin
            r_rd_owner <= OWN_NONE;
        end
    end

    assign w_a_rvalid = !i_reset && (r_rd_owner == OWN_A);
    assign w_b_rvalid = !i_reset && (r_rd_owner == OWN_B);

    // Read data is passed straight through on its valid cycle and held afterwards.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            if (w_a_rvalid) r_a_rdata <= i_mem_rdata;
            if (w_b_rvalid) r_b_rdata <= i_mem_rdata;
        end
    end

    assign o_a_rvalid = w_a_rvalid;
    assign o_b_rvalid = w_b_rvalid;
    assign o_a_rdata  = w_a_rvalid ? i_mem_rdata : r_a_rdata;
    assign o_b_rdata  = w_b_rvalid ? i_mem_rdata : r_b_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [CNT_BITS-1:0] r_stat_a;
    logic [CNT_BITS-1:0] r_stat_b;
    logic [CNT_BITS-1:0] r_stat_c;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stat_a <= '0;
            r_stat_b <= '0;
            r_stat_c <= '0;
        end else begin
            if (w_a_gnt && r_stat_a != '1)
                r_stat_a <= r_stat_a + 1'b1;
            if (w_b_gnt && r_stat_b != '1)
                r_stat_b <= r_stat_b + 1'b1;
            if (i_a_req && i_b_req && r_stat_c != '1)
                r_stat_c <= r_stat_c + 1'b1;
        end
    end

    assign o_stat_a_cnt        = r_stat_a;
    assign o_stat_b_cnt        = r_stat_b;
    assign o_stat_conflict_cnt = r_stat_c;
`endif

endmodule
